cache_ctrl_fsm: RTL and testbench

Sequencing controller for the 4-way set-associative cache with 128 sets. It owns the tag, valid, dirty and per-way LRU state. It accepts one CPU request at a time, performs tag compare, selects LRU victims, and drives dirty writeback and refill handshakes toward memory. It drives the external data array through way/write-enable/fill strobes.

---
 rtl/cache_ctrl_if.sv | 34 +++
 rtl/cache_ctrl_fsm.sv | 156 +++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_if.sv
// CPU request/response, data-array strobes, memory handshake and statistics
// for the 4-way cache controller. slave = controller side, master = environment.
interface cache_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int STAT_W = 16
);
    logic              cpu_req_valid;
    logic              cpu_req_rw;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic              cpu_ready;
    logic              cpu_done;
    logic              cpu_hit;
    logic [1:0]        data_way;
    logic              data_we;
    logic              data_fill;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [STAT_W-1:0] hit_cnt;
    logic [STAT_W-1:0] miss_cnt;

    modport slave (
        input  cpu_req_valid, cpu_req_rw, cpu_req_addr, mem_ack,
        output cpu_ready, cpu_done, cpu_hit, data_way, data_we, data_fill,
               mem_req, mem_we, mem_addr, hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req_valid, cpu_req_rw, cpu_req_addr, mem_ack,
        input  cpu_ready, cpu_done, cpu_hit, data_way, data_we, data_fill,
               mem_req, mem_we, mem_addr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for a 4-way, 128-set cache: owns tag/valid/dirty/LRU
// state, resolves hits, picks victims and runs writeback/refill handshakes.
//
// state     | meaning
// IDLE      | cpu_ready=1, waiting for a request
// COMPARE   | one-cycle tag lookup; completes on hit, picks victim on miss
// WRITEBACK | dirty victim line being written to memory
// ALLOCATE  | requested line being read from memory into the victim way
module cache_ctrl_fsm #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 7,
    parameter int OFFSET_W = 6,
    parameter int STAT_W   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    cache_ctrl_if.slave  bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS  = 1 << INDEX_W;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
    state_t state, state_nxt;

    logic [TAG_W-1:0] tag_arr   [SETS][4];
    logic [3:0]       valid_arr [SETS];
    logic [3:0]       dirty_arr [SETS];
    logic [1:0]       lru_arr   [SETS][4];

    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] idx_q;
    logic               rw_q;
    logic               miss_q;
    logic [1:0]         victim_q;
    logic [STAT_W-1:0]  hit_cnt_q;
    logic [STAT_W-1:0]  miss_cnt_q;

    logic [3:0] way_hit;
    logic       hit;
    logic [1:0] hit_way;
    logic [1:0] victim;

    // Victim: the LRU way unless some way is invalid, then the lowest invalid one.
    always_comb begin
        way_hit = '0;
        hit_way = 2'd0;
        victim  = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            way_hit[w] = valid_arr[idx_q][w] && (tag_arr[idx_q][w] == tag_q);
            if (way_hit[w]) hit_way = 2'(w);
            if (lru_arr[idx_q][w] == 2'd0) victim = 2'(w);
        end
        for (int w = 3; w >= 0; w--) begin
            if (!valid_arr[idx_q][w]) victim = 2'(w);
        end
    end

    assign hit = |way_hit;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.cpu_req_valid) state_nxt = COMPARE;
            COMPARE: begin
                if (hit)
                    state_nxt = IDLE;
                else if (valid_arr[idx_q][victim] && dirty_arr[idx_q][victim])
                    state_nxt = WRITEBACK;
                else
                    state_nxt = ALLOCATE;
            end
            WRITEBACK: if (bus.mem_ack) state_nxt = ALLOCATE;
            ALLOCATE:  if (bus.mem_ack) state_nxt = COMPARE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign bus.cpu_ready = (state == IDLE);
    assign bus.cpu_done  = (state == COMPARE) && hit;
    assign bus.cpu_hit   = bus.cpu_done && !miss_q;
    assign bus.data_we   = bus.cpu_done && rw_q;
    assign bus.data_fill = (state == ALLOCATE) && bus.mem_ack;
    assign bus.data_way  = bus.cpu_done  ? hit_way  :
                           bus.data_fill ? victim_q : 2'd0;
    assign bus.mem_req   = (state == WRITEBACK) || (state == ALLOCATE);
    assign bus.mem_we    = (state == WRITEBACK);
    assign bus.mem_addr  = (state == WRITEBACK) ? {tag_arr[idx_q][victim_q], idx_q, {OFFSET_W{1'b0}}} :
                           (state == ALLOCATE)  ? {tag_q, idx_q, {OFFSET_W{1'b0}}} : '0;
    assign bus.hit_cnt   = hit_cnt_q;
    assign bus.miss_cnt  = miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tag_q      <= '0;
            idx_q      <= '0;
            rw_q       <= 1'b0;
            miss_q     <= 1'b0;
            victim_q   <= 2'd0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= 4'd0;
                dirty_arr[s] <= 4'd0;
                for (int w = 0; w < 4; w++) lru_arr[s][w] <= 2'(w);
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.cpu_req_valid) begin
                        tag_q  <= bus.cpu_req_addr[ADDR_W-1 -: TAG_W];
                        idx_q  <= bus.cpu_req_addr[OFFSET_W +: INDEX_W];
                        rw_q   <= bus.cpu_req_rw;
                        miss_q <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (rw_q) dirty_arr[idx_q][hit_way] <= 1'b1;
                        for (int w = 0; w < 4; w++) begin
                            if (2'(w) == hit_way)
                                lru_arr[idx_q][w] <= 2'd3;
                            else if (lru_arr[idx_q][w] > lru_arr[idx_q][hit_way])
                                lru_arr[idx_q][w] <= lru_arr[idx_q][w] - 2'd1;
                        end
                        if (!miss_q && hit_cnt_q != STAT_MAX)
                            hit_cnt_q <= hit_cnt_q + STAT_W'(1);
                    end else begin
                        miss_q   <= 1'b1;
                        victim_q <= victim;
                        if (miss_cnt_q != STAT_MAX)
                            miss_cnt_q <= miss_cnt_q + STAT_W'(1);
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ack) dirty_arr[idx_q][victim_q] <= 1'b0;
                end
                ALLOCATE: begin
                    if (bus.mem_ack) begin
                        valid_arr[idx_q][victim_q] <= 1'b1;
                        dirty_arr[idx_q][victim_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tags are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == ALLOCATE && bus.mem_ack)
            tag_arr[idx_q][victim_q] <= tag_q;
    end
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Scoreboard bench for cache_ctrl_fsm: a recency-timestamp cache model predicts
// memory transactions, fills and completions; a monitor compares them as they occur.
module tb_cache_ctrl_fsm;
    localparam int ADDR_W = 32;
    localparam int STAT_W = 10;  // narrowed so saturation is reachable in a short run
    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    localparam int STAT_MAX_I = (1 << STAT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl_if #(.ADDR_W(ADDR_W), .STAT_W(STAT_W)) bus ();
    cache_ctrl_fsm #(.ADDR_W(ADDR_W), .STAT_W(STAT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: LRU = oldest access timestamp in the set.
    logic [18:0] m_tag   [128][4];
    bit          m_valid [128][4];
    bit          m_dirty [128][4];
    longint      m_stamp [128][4];
    longint      m_now;
    int          m_hits, m_misses;

    logic [32:0] exp_mem[$];   // {we, addr}
    logic [1:0]  exp_fill[$];  // way
    logic [3:0]  exp_done[$];  // {hit, we, way}

    function automatic void model_reset();
        for (int s = 0; s < 128; s++)
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_stamp[s][w] = longint'(w) - 4;
            end
        m_now = 0;
        m_hits = 0;
        m_misses = 0;
        exp_mem.delete();
        exp_fill.delete();
        exp_done.delete();
    endfunction

    task automatic model_req(input logic rw, input logic [31:0] addr);
        logic [18:0] tag;
        int idx, way;
        tag = addr[31:13];
        idx = int'(addr[12:6]);
        way = -1;
        for (int w = 0; w < 4; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tag) way = w;
        if (way >= 0) begin
            if (m_hits < STAT_MAX_I) m_hits++;
            exp_done.push_back({1'b1, rw, 2'(way)});
        end else begin
            if (m_misses < STAT_MAX_I) m_misses++;
            way = 0;
            for (int w = 1; w < 4; w++)
                if (m_stamp[idx][w] < m_stamp[idx][way]) way = w;
            for (int w = 3; w >= 0; w--)
                if (!m_valid[idx][w]) way = w;
            if (m_valid[idx][way] && m_dirty[idx][way])
                exp_mem.push_back({1'b1, m_tag[idx][way], 7'(idx), 6'd0});
            exp_mem.push_back({1'b0, tag, 7'(idx), 6'd0});
            exp_fill.push_back(2'(way));
            m_tag[idx][way]   = tag;
            m_valid[idx][way] = 1;
            m_dirty[idx][way] = 0;
            exp_done.push_back({1'b0, rw, 2'(way)});
        end
        m_now++;
        m_stamp[idx][way] = m_now;
        if (rw) m_dirty[idx][way] = 1;
    endtask

    // Memory responder: 0 = per-phase wait (fixed or random 0..3), 1 = ack held high.
    int ack_mode = 0;
    int fixed_wait = -1;
    initial begin
        int  wait_cnt;
        bit  armed;
        wait_cnt = 0;
        armed = 0;
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ack_mode == 1) begin
                bus.mem_ack = 1'b1;
            end else if (!bus.mem_req) begin
                bus.mem_ack = 1'b0;
                armed = 0;
            end else begin
                if (!armed) begin
                    wait_cnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
                    armed = 1;
                end
                if (wait_cnt == 0) begin
                    bus.mem_ack = 1'b1;
                    armed = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    wait_cnt--;
                end
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT presents an event.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.mem_req && bus.mem_ack) begin
                    if (exp_mem.size() == 0) check("mem_unexpected", {bus.mem_we, bus.mem_addr}, 0);
                    else check("mem_txn", {bus.mem_we, bus.mem_addr}, exp_mem.pop_front());
                end
                if (bus.data_fill) begin
                    if (exp_fill.size() == 0) check("fill_unexpected", {1'b1, bus.data_way}, 0);
                    else check("fill_way", bus.data_way, exp_fill.pop_front());
                end
                if (bus.cpu_done) begin
                    if (exp_done.size() == 0) check("done_unexpected", {1'b1, bus.cpu_hit, bus.data_we, bus.data_way}, 0);
                    else check("done_hit_we_way", {bus.cpu_hit, bus.data_we, bus.data_way}, exp_done.pop_front());
                end
            end
        end
    end

    function automatic logic [31:0] mk(input int tag, input int idx);
        return {19'(tag), 7'(idx), 6'd0};
    endfunction

    task automatic do_req(input logic rw, input logic [31:0] addr, output int lat);
        int guard;
        guard = 0;
        while (!bus.cpu_ready && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_before_req", bus.cpu_ready, 1);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_rw    = rw;
        bus.cpu_req_addr  = addr;
        model_req(rw, addr);
        @(posedge clk); #1;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_addr  = $urandom;
        lat = 1;
        while (!bus.cpu_done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", bus.cpu_done, 1);
        @(posedge clk); #1;
        check("hit_cnt", bus.hit_cnt, m_hits);
        check("miss_cnt", bus.miss_cnt, m_misses);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int guard;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_rw    = 1'b0;
        bus.cpu_req_addr  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.cpu_ready, 1);
        check("rst_done_hit_we_fill", {bus.cpu_done, bus.cpu_hit, bus.data_we, bus.data_fill}, 0);
        check("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr}, 0);
        check("rst_way", bus.data_way, 0);
        check("rst_counters", {bus.hit_cnt, bus.miss_cnt}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean miss with 3-cycle memory wait, then a hit on the same line.
        fixed_wait = 3;
        do_req(1'b0, 32'h0000_0040, lat);
        check("clean_miss_lat", lat, 6);
        do_req(1'b0, 32'h0000_0040, lat);
        check("hit_lat", lat, 1);

        // Fill set 1 with tags 1..4, touch tag 1, then tag 5 evicts clean way 1.
        fixed_wait = 0;
        for (int t = 1; t <= 4; t++) do_req(1'b0, mk(t, 1), lat);
        do_req(1'b0, mk(1, 1), lat);
        do_req(1'b0, mk(5, 1), lat);
        check("clean_evict_lat", lat, 3);

        // Write hit to tag 3 (way 2), make way 2 LRU, then evict it dirty.
        do_req(1'b1, mk(3, 1), lat);
        do_req(1'b0, mk(1, 1), lat);
        do_req(1'b0, mk(5, 1), lat);
        do_req(1'b0, mk(4, 1), lat);
        fixed_wait = 2;
        do_req(1'b0, mk(6, 1), lat);
        check("dirty_miss_lat", lat, 8);

        // Same dirty eviction pattern with mem_ack held high throughout.
        do_req(1'b1, mk(6, 1), lat);
        do_req(1'b0, mk(1, 1), lat);
        do_req(1'b0, mk(5, 1), lat);
        do_req(1'b0, mk(4, 1), lat);
        ack_mode = 1;
        do_req(1'b0, mk(7, 1), lat);
        check("ack_high_dirty_lat", lat, 4);
        ack_mode = 0;
        fixed_wait = -1;

        // Randomised traffic over a small tag/index space to force conflicts.
        for (int i = 0; i < 300; i++)
            do_req(1'(($urandom >> 3) & 1),
                   {19'($urandom_range(0, 7)), 7'($urandom_range(0, 3)), 6'($urandom)}, lat);

        // Reset while ALLOCATE is waiting for its ack.
        fixed_wait = 20;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_rw    = 1'b0;
        bus.cpu_req_addr  = mk(9, 5);
        @(posedge clk); #1;
        bus.cpu_req_valid = 1'b0;
        guard = 0;
        while (!(bus.mem_req && !bus.mem_we) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("alloc_reached", {bus.mem_req, bus.mem_we}, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", bus.mem_req, 0);
        check("rst_mid_ready", bus.cpu_ready, 1);
        check("rst_mid_counters", {bus.hit_cnt, bus.miss_cnt}, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_mode = 1;
        repeat (3) begin
            @(posedge clk); #1;
            check("late_ack_ignored", {bus.cpu_ready, bus.mem_req, bus.cpu_done}, 3'b100);
        end
        ack_mode = 0;
        fixed_wait = -1;
        do_req(1'b0, mk(1, 1), lat);
        do_req(1'b0, mk(7, 1), lat);
        do_req(1'b0, 32'h0000_0040, lat);

        // Drive hit_cnt to saturation and one step past it.
        for (int i = 0; i < STAT_MAX_I; i++) do_req(1'b0, 32'h0000_0040, lat);
        check("hit_cnt_at_max", bus.hit_cnt, STAT_MAX);
        do_req(1'b0, 32'h0000_0040, lat);
        check("hit_cnt_saturated", bus.hit_cnt, STAT_MAX);

        repeat (3) @(posedge clk);
        check("queues_drained", exp_mem.size() + exp_fill.size() + exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
